// File: rtl/cii_pkg.sv
// cii_pkg: shared FSM encoding, entry limit and CII field widths for the capability table
package cii_pkg;
  localparam int MAX_ENTRIES = 8;
  localparam int CII_ADDR_W = 10;
  localparam int CII_DATA_W = 32;
  localparam int CII_BE_W = 4;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/cii_entry_match.sv
// cii_entry_match: priority address compare (addr in; hit, idx out), lowest matching entry wins
module cii_entry_match
  import cii_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*CII_ADDR_W-1:0] ENTRY_ADDR = {10'h018, 10'h019, 10'h01a, 10'h00d}
) (
  input  logic [CII_ADDR_W-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (addr == ENTRY_ADDR[i*CII_ADDR_W+:CII_ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/cii_cap_table.sv
// cii_cap_table: intercepts CII config dwords (req/addr/wr/be/dout in; halt, read override and cap_wr update notice out)
module cii_cap_table
  import cii_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int HALT_LAT = 2,
  parameter logic [NUM_ENTRIES*CII_ADDR_W-1:0] ENTRY_ADDR = {10'h018, 10'h019, 10'h01a, 10'h00d},
  parameter logic [NUM_ENTRIES*CII_DATA_W-1:0] ENTRY_INIT = {32'h0, 32'h0, 32'h0, 32'h060},
  parameter logic [NUM_ENTRIES*CII_DATA_W-1:0] ENTRY_WMASK = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cii_req,
  input  logic                  cii_hdr_poisoned,
  input  logic                  cii_wr,
  input  logic [CII_BE_W-1:0]   cii_hdr_first_be,
  input  logic [CII_ADDR_W-1:0] cii_addr,
  input  logic [CII_DATA_W-1:0] cii_dout,
  output logic                  cii_override_en,
  output logic [CII_DATA_W-1:0] cii_override_din,
  output logic                  cii_halt,
  output logic                  cap_wr_valid,
  output logic [IDX_W-1:0]      cap_wr_idx,
  output logic [CII_DATA_W-1:0] cap_wr_data
);
  state_t state;
  logic [3:0] cnt;
  logic req_q, armed;
  logic [CII_ADDR_W-1:0] addr_q;
  logic wr_q, pois_q;
  logic [CII_BE_W-1:0] be_q;
  logic [CII_DATA_W-1:0] dout_q;
  logic [CII_DATA_W-1:0] shadow [NUM_ENTRIES];
  logic edge_det, go_resp, from_idle, w_sel, p_sel, hit, do_wr, do_rd;
  logic [CII_ADDR_W-1:0] a_sel;
  logic [CII_BE_W-1:0] be_sel;
  logic [CII_DATA_W-1:0] d_sel, sel_sh, sel_m, m, nv;
  logic [IDX_W-1:0] idx;
  // armed stays low after reset until cii_req has been seen low, so a request held across reset is not an edge
  assign edge_det = cii_req & ~req_q & armed & (state == IDLE);
  assign go_resp = (edge_det && HALT_LAT == 0) || (state == WAIT && cnt == 4'd0);
  // outputs are registered on entry to RESP, so with zero latency the live request fields are used
  assign from_idle = (state == IDLE);
  assign a_sel = from_idle ? cii_addr : addr_q;
  assign w_sel = from_idle ? cii_wr : wr_q;
  assign p_sel = from_idle ? cii_hdr_poisoned : pois_q;
  assign be_sel = from_idle ? cii_hdr_first_be : be_q;
  assign d_sel = from_idle ? cii_dout : dout_q;
  cii_entry_match #(.NUM_ENTRIES(NUM_ENTRIES), .ENTRY_ADDR(ENTRY_ADDR)) u_match (
    .addr(a_sel),
    .hit (hit),
    .idx (idx)
  );
  always_comb begin
    sel_sh = '0;
    sel_m = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (idx == IDX_W'(i)) begin
        sel_sh = shadow[i];
        sel_m = ENTRY_WMASK[i*CII_DATA_W+:CII_DATA_W];
      end
  end
  assign m = sel_m & {{8{be_sel[3]}}, {8{be_sel[2]}}, {8{be_sel[1]}}, {8{be_sel[0]}}};
  assign nv = (sel_sh & ~m) | (d_sel & m);
  assign do_wr = go_resp & hit & w_sel & ~p_sel;
  assign do_rd = go_resp & hit & ~w_sel;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      req_q <= 1'b0;
      armed <= 1'b0;
      addr_q <= '0;
      wr_q <= 1'b0;
      pois_q <= 1'b0;
      be_q <= '0;
      dout_q <= '0;
      cii_halt <= 1'b1;
      cii_override_en <= 1'b0;
      cii_override_din <= '0;
      cap_wr_valid <= 1'b0;
      cap_wr_idx <= '0;
      cap_wr_data <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) shadow[i] <= ENTRY_INIT[i*CII_DATA_W+:CII_DATA_W];
    end else begin
      req_q <= cii_req;
      armed <= armed | ~cii_req;
      cii_halt <= ~go_resp;
      cii_override_en <= do_rd;
      cii_override_din <= do_rd ? sel_sh : '0;
      cap_wr_valid <= do_wr;
      cap_wr_idx <= do_wr ? idx : '0;
      cap_wr_data <= do_wr ? nv : '0;
      for (int i = 0; i < NUM_ENTRIES; i++) if (do_wr && idx == IDX_W'(i)) shadow[i] <= nv;
      if (edge_det) begin
        addr_q <= cii_addr;
        wr_q <= cii_wr;
        pois_q <= cii_hdr_poisoned;
        be_q <= cii_hdr_first_be;
        dout_q <= cii_dout;
        state <= (HALT_LAT == 0) ? RESP : WAIT;
        cnt <= (HALT_LAT == 0) ? 4'd0 : 4'(HALT_LAT - 1);
      end else if (state == WAIT) begin
        state <= (cnt == 4'd0) ? RESP : WAIT;
        cnt <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_cii_cap_table.sv
// tb_cii_cap_table: table-driven scoreboard bench for cii_cap_table at HALT_LAT=2 and HALT_LAT=0
module tb_cii_cap_table;
  typedef struct {
    logic wr; logic pois; logic [3:0] be; logic [9:0] addr; logic [31:0] dout;
    logic ov; logic [31:0] din; logic cv; logic [2:0] idx; logic [31:0] cd;
  } vec_t;
  typedef struct {
    int cyc; logic ov; logic [31:0] din; logic cv; logic [2:0] idx; logic [31:0] cd;
  } exp_t;
  logic clk = 0, reset_n = 0, req0 = 0, req1 = 0, pois = 0, wr = 0;
  logic [3:0] be = 0;
  logic [9:0] addr = 0;
  logic [31:0] dout = 0;
  logic ov0, halt0, cv0, ov1, halt1, cv1;
  logic [31:0] din0, cd0, din1, cd1;
  logic [2:0] idx0, idx1;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  vec_t vecs[12];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  cii_cap_table #(.HALT_LAT(2), .ENTRY_WMASK({32'h0, 32'h0, 32'h0000FFFF, 32'h0})) u0 (
    .clk(clk), .reset_n(reset_n), .cii_req(req0), .cii_hdr_poisoned(pois), .cii_wr(wr),
    .cii_hdr_first_be(be), .cii_addr(addr), .cii_dout(dout), .cii_override_en(ov0),
    .cii_override_din(din0), .cii_halt(halt0), .cap_wr_valid(cv0), .cap_wr_idx(idx0), .cap_wr_data(cd0));
  cii_cap_table #(.HALT_LAT(0)) u1 (
    .clk(clk), .reset_n(reset_n), .cii_req(req1), .cii_hdr_poisoned(pois), .cii_wr(wr),
    .cii_hdr_first_be(be), .cii_addr(addr), .cii_dout(dout), .cii_override_en(ov1),
    .cii_override_din(din1), .cii_halt(halt1), .cap_wr_valid(cv1), .cap_wr_idx(idx1), .cap_wr_data(cd1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic resp_chk(input string tag, input exp_t e, input logic ov, input logic [31:0] din,
                          input logic cv, input logic [2:0] idx, input logic [31:0] cd);
    chk({tag, "_resp_cycle"}, cyc, e.cyc);
    chk({tag, "_ov_en"}, {31'b0, ov}, {31'b0, e.ov});
    chk({tag, "_ov_din"}, din, e.din);
    chk({tag, "_cap_valid"}, {31'b0, cv}, {31'b0, e.cv});
    chk({tag, "_cap_idx"}, {29'b0, idx}, {29'b0, e.idx});
    chk({tag, "_cap_data"}, cd, e.cd);
  endtask
  always @(negedge clk) begin
    if (!halt0) begin
      if (q0.size() == 0) chk("u0_unexpected_resp", 32'd1, 32'd0);
      else resp_chk("u0", q0.pop_front(), ov0, din0, cv0, idx0, cd0);
    end else chk("u0_idle_outputs", {ov0, cv0, din0[29:0] | cd0[29:0]}, 32'd0);
    if (!halt1) begin
      if (q1.size() == 0) chk("u1_unexpected_resp", 32'd1, 32'd0);
      else resp_chk("u1", q1.pop_front(), ov1, din1, cv1, idx1, cd1);
    end else chk("u1_idle_outputs", {ov1, cv1, din1[29:0] | cd1[29:0]}, 32'd0);
  end
  task automatic drive(input vec_t v);
    addr = v.addr; wr = v.wr; pois = v.pois; be = v.be; dout = v.dout;
  endtask
  task automatic issue(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    req0 = 1;
    q0.push_back('{cyc + 3, v.ov, v.din, v.cv, v.idx, v.cd});
    @(posedge clk); #1;
    req0 = 0;
  endtask
  task automatic drain();
    for (int n = 0; n < 20 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clk);
    @(posedge clk);
    chk("drain_timeout", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask
  function automatic vec_t rd(input logic [9:0] a, input logic ov, input logic [31:0] d);
    return '{1'b0, 1'b0, 4'hf, a, 32'h0, ov, d, 1'b0, 3'd0, 32'h0};
  endfunction
  initial begin
    vecs[0]  = rd(10'h00d, 1, 32'h060);
    vecs[1]  = rd(10'h01a, 1, 32'h0);
    vecs[2]  = '{1, 0, 4'b0001, 10'h01a, 32'hABCD1234, 0, 32'h0, 1, 3'd1, 32'h00000034};
    vecs[3]  = rd(10'h01a, 1, 32'h34);
    vecs[4]  = '{1, 1, 4'b0001, 10'h01a, 32'hABCD1234, 0, 32'h0, 0, 3'd0, 32'h0};
    vecs[5]  = rd(10'h01a, 1, 32'h34);
    vecs[6]  = rd(10'h100, 0, 32'h0);
    vecs[7]  = '{1, 0, 4'hf, 10'h00d, 32'hFFFFFFFF, 0, 32'h0, 1, 3'd0, 32'h060};
    vecs[8]  = '{1, 0, 4'b0110, 10'h01a, 32'h11223344, 0, 32'h0, 1, 3'd1, 32'h00003334};
    vecs[9]  = rd(10'h01a, 1, 32'h3334);
    vecs[10] = '{1, 0, 4'hf, 10'h100, 32'h12345678, 0, 32'h0, 0, 3'd0, 32'h0};
    vecs[11] = rd(10'h019, 1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_halt", {31'b0, halt0}, 32'd1);
    chk("reset_ov_en", {31'b0, ov0}, 32'd0);
    chk("reset_cap_valid", {31'b0, cv0}, 32'd0);
    reset_n = 1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i]);
      drain();
    end
    @(posedge clk); #1;
    drive(rd(10'h01a, 0, 0));
    req0 = 1;
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    chk("midreset_halt", {31'b0, halt0}, 32'd1);
    chk("midreset_ov_en", {31'b0, ov0}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (8) @(posedge clk);
    #1;
    req0 = 0;
    repeat (2) @(posedge clk);
    issue(rd(10'h01a, 1, 32'h0));
    drain();
    issue(rd(10'h00d, 1, 32'h060));
    drain();
    @(posedge clk); #1;
    drive(rd(10'h00d, 0, 0));
    req1 = 1;
    q1.push_back('{cyc + 1, 1, 32'h060, 0, 3'd0, 32'h0});
    @(posedge clk); #1;
    req1 = 0;
    @(posedge clk); #1;
    req1 = 1;
    q1.push_back('{cyc + 1, 1, 32'h060, 0, 3'd0, 32'h0});
    @(posedge clk); #1;
    req1 = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cii_cap_table.md
CII_CAP_TABLE -- requirements
Module: cii_cap_table

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning number of intercepted config dwords (1..8).
REQ-002 SHALL have parameter HALT_LAT, default 2, meaning extra cycles cii_halt stays high after a request edge (0..15).
REQ-003 SHALL have parameter ENTRY_ADDR, default {10'h018,10'h019,10'h01a,10'h00d}, meaning packed NUM_ENTRIES x 10-bit dword addresses, entry 0 in the LSBs.
REQ-004 SHALL have parameter ENTRY_INIT, default {32'h0,32'h0,32'h0,32'h060}, meaning packed NUM_ENTRIES x 32-bit reset read values.
REQ-005 SHALL have parameter ENTRY_WMASK, default all zero, meaning packed NUM_ENTRIES x 32-bit writable-bit masks.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have ports cii_req, cii_hdr_poisoned, cii_wr, input, 1 each, meaning the request, poisoned and write qualifiers.
REQ-009 SHALL have ports cii_hdr_first_be (4), cii_addr (10) and cii_dout (32), all inputs, meaning byte enables, dword address and write data.
REQ-010 SHALL have ports cii_override_en (1), cii_override_din (32) and cii_halt (1), all outputs, meaning read override and halt.
REQ-011 SHALL have ports cap_wr_valid (1), cap_wr_idx (3) and cap_wr_data (32), all outputs, meaning a 1-cycle notice that an entry was updated.

Function
REQ-012 SHALL have FSM states IDLE, WAIT and RESP.
REQ-013 SHALL detect a request edge as cii_req high while the previous-cycle cii_req was low, acted on only in IDLE; edges in other states are ignored.
REQ-014 SHALL, on a request edge, register cii_addr, cii_wr, cii_hdr_first_be, cii_dout and cii_hdr_poisoned, then go to WAIT if HALT_LAT>0, else to RESP.
REQ-015 SHALL hold a 4-bit down-counter in WAIT loaded with HALT_LAT-1, and go to RESP when it reaches 0.
REQ-016 SHALL hold cii_halt high in IDLE and WAIT and low for exactly the one RESP cycle, then return to IDLE.
REQ-017 SHALL declare a hit when the registered address equals ENTRY_ADDR[i]; the lowest index wins on duplicates.
REQ-018 SHALL, in RESP on a read hit, drive cii_override_en=1 and cii_override_din=shadow[i]; otherwise both are 0.
REQ-019 SHALL, in RESP on a write hit with poisoned=0, set shadow[i] per bit b to cii_dout[b] where ENTRY_WMASK[i][b]=1 and first_be[b/8]=1, else keep it.
REQ-020 SHALL, in the same RESP cycle as a write hit with poisoned=0, pulse cap_wr_valid=1 with cap_wr_idx=i and cap_wr_data=the new shadow value.
REQ-021 SHALL discard poisoned writes: no shadow change, no cap_wr_valid, halt sequence unchanged.
REQ-022 SHALL treat misses as pass-through: halt sequence only, no override, no update.
REQ-023 SHALL give a request edge at cycle T a RESP cycle of T+1+HALT_LAT.
REQ-024 SHALL hold cii_override_en, cii_override_din and cap_wr_* at 0 outside RESP.

Reset
REQ-025 SHALL, while reset_n is low, force state=IDLE, cii_halt=1, cii_override_en=0, cii_override_din=0, cap_wr_*=0, request history=0 and shadow[i]=ENTRY_INIT[i].
REQ-026 SHALL, on reset mid-request, abandon the request; a cii_req still high after reset release is not an edge until it falls and rises again.

Structure
REQ-027 SHALL place the FSM state encoding, the MAX_ENTRIES=8 constant and the CII field widths in the shared package cii_pkg.
REQ-028 SHALL use one sub-module, cii_entry_match, for the priority address compare producing hit and index.
REQ-029 SHALL implement the shadow registers as flops, not RAM.

Verification
REQ-030 SHALL cover: HALT_LAT=2, read addr 0x00d edge at T -> cii_halt low only at T+3, override_en=1, din=0x060.
REQ-031 SHALL cover: entry 1 WMASK=0x0000FFFF, write 0xABCD1234 with be=0b0001 -> cap_wr_data=0x00000034, and a later read returns 0x00000034.
REQ-032 SHALL cover: the same write with cii_hdr_poisoned=1 -> no cap_wr_valid, and a read returns the unchanged value.
REQ-033 SHALL cover: read addr 0x100 (miss) -> override_en=0 and halt low for one cycle.
REQ-034 SHALL cover: reset asserted during WAIT -> cii_halt=1, shadow back to ENTRY_INIT, and no response until a fresh cii_req edge.
REQ-035 SHALL cover: HALT_LAT=0 back-to-back requests with cii_req low for 1 cycle -> two separate 1-cycle RESP pulses.
